// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, write-back, write-allocate data cache controller
// sitting between the MEM stage and a word-wide req/gnt memory bus.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   rd_req, wr_req      MEM-stage load / store (store wins if both are high)
//   addr, wr_data       byte address (bits [1:0] ignored) and store word
//   rd_data             load word, combinational on a hit, 0 otherwise
//   miss                stall request to the hazard unit (DCacheMiss)
//   mem_rd_req          word read request (refill)
//   mem_wr_req          word write request (victim write-back)
//   mem_addr            word-aligned memory address, 0 when idle
//   mem_wr_data         write-back word, 0 when idle
//   mem_rd_data         refill word, valid while mem_gnt is high during a read
//   mem_gnt             one-cycle accept/completion of the current word
module dcache_ctrl #(
    parameter int LINE_ADDR_LEN = 2,
    parameter int SET_ADDR_LEN  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_gnt
);

    localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int WORDS   = 1 << LINE_ADDR_LEN;
    localparam int SETS    = 1 << SET_ADDR_LEN;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    logic [1:0]               state;
    logic [LINE_ADDR_LEN-1:0] cnt;
    logic [SETS-1:0]          valid;
    logic [SETS-1:0]          dirty;

    // Line storage: tags and words carry no reset, only valid/dirty do.
    logic [TAG_LEN-1:0]       tags  [SETS];
    logic [31:0]              words [SETS][WORDS];

    // Request captured when the miss is detected; the line operation runs
    // from these, so the MEM-stage inputs are only looked at in IDLE.
    logic [TAG_LEN-1:0]       miss_tag;
    logic [SET_ADDR_LEN-1:0]  miss_idx;

    logic [TAG_LEN-1:0]       req_tag;
    logic [SET_ADDR_LEN-1:0]  req_idx;
    logic [LINE_ADDR_LEN-1:0] req_word;
    logic                     unused_byte_bits;

    logic idle;
    logic req_any;
    logic hit;
    logic write_hit;
    logic start_miss;
    logic last_word;
    logic fill_grant;
    logic fill_done;

    assign req_tag          = addr[31 -: TAG_LEN];
    assign req_idx          = addr[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign req_word         = addr[2 +: LINE_ADDR_LEN];
    assign unused_byte_bits = ^addr[1:0];

    assign idle       = (state == IDLE);
    assign req_any    = rd_req | wr_req;
    assign hit        = valid[req_idx] && (tags[req_idx] == req_tag);
    // A store takes priority over a simultaneous load, so any write request
    // that hits is treated as a store.
    assign write_hit  = idle && wr_req && hit;
    assign start_miss = idle && req_any && !hit;
    assign last_word  = (cnt == {LINE_ADDR_LEN{1'b1}});
    assign fill_grant = (state == FILL) && mem_gnt;
    assign fill_done  = fill_grant && last_word;

    // Combinational so the stall is seen by the pipeline in the miss cycle.
    assign miss    = !idle || (req_any && !hit);
    assign rd_data = (idle && hit) ? words[req_idx][req_word] : 32'h0;

    assign mem_wr_req = (state == WB);
    assign mem_rd_req = (state == FILL);

    always_comb begin
        mem_addr    = 32'h0;
        mem_wr_data = 32'h0;
        if (state == WB) begin
            mem_addr    = {tags[miss_idx], miss_idx, cnt, 2'b00};
            mem_wr_data = words[miss_idx][cnt];
        end else if (state == FILL) begin
            mem_addr    = {miss_tag, miss_idx, cnt, 2'b00};
        end
    end

    // Control: state, word counter, valid and dirty bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_miss) begin
                        cnt   <= '0;
                        state <= (valid[req_idx] && dirty[req_idx]) ? WB : FILL;
                    end else if (write_hit) begin
                        dirty[req_idx] <= 1'b1;
                    end
                end
                WB: begin
                    if (mem_gnt) begin
                        // cnt wraps to 0 on the last word, ready for FILL.
                        cnt <= cnt + 1'b1;
                        if (last_word) begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_gnt) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) begin
                            valid[miss_idx] <= 1'b1;
                            dirty[miss_idx] <= 1'b0;
                            state           <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: captured miss address, line words and tags.
    always_ff @(posedge clk) begin
        if (start_miss) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
        end
        if (write_hit) begin
            words[req_idx][req_word] <= wr_data;
        end
        if (fill_grant) begin
            words[miss_idx][cnt] <= mem_rd_data;
        end
        if (fill_done) begin
            tags[miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected memory transfers and load data
// are queued when a request is driven and popped as the DUT produces them.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_gnt;

    dcache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_gnt     (mem_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       mem_q [$];
    logic [31:0] rd_q  [$];

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem [256];
    bit          mem_inited = 1'b0;
    int          gnt_period = 1;
    int          wcnt       = 0;
    logic        prev_wait  = 1'b0;
    logic [31:0] prev_addr  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int widx);
        return 32'h0FC + widx;
    endfunction

    assign mem_rd_data = mem_rd_req ? mem[mem_addr[9:2]] : 32'h0;

    // Memory model and transfer monitor. Grants are decided here for the
    // cycle in progress; a granted transfer completes at the next rising edge.
    always @(negedge clk) begin
        logic  act;
        logic  gnt;
        xfer_t e;
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            mem_inited = 1'b1;
        end
        act = mem_rd_req | mem_wr_req;
        if (act) begin
            chk("req_excl", {31'h0, mem_rd_req & mem_wr_req}, 32'h0);
            if (prev_wait) chk("addr_stable", mem_addr, prev_addr);
            gnt  = (wcnt == gnt_period - 1);
            wcnt = gnt ? 0 : wcnt + 1;
        end else begin
            chk("idle_mem_addr", mem_addr, 32'h0);
            chk("idle_mem_wdata", mem_wr_data, 32'h0);
            gnt  = 1'b0;
            wcnt = 0;
        end
        mem_gnt   = gnt;
        prev_wait = act && !gnt;
        prev_addr = mem_addr;
        if (act && gnt) begin
            if (mem_q.size() == 0) begin
                chk("xfer_unexpected", mem_addr, 32'hFFFF_FFFF);
            end else begin
                e = mem_q.pop_front();
                chk("xfer_kind", {31'h0, mem_wr_req}, {31'h0, e.wr});
                chk("xfer_addr", mem_addr, e.a);
                if (e.wr) begin
                    chk("xfer_wdata", mem_wr_data, e.d);
                    mem[mem_addr[9:2]] = mem_wr_data;
                end
            end
        end
    end

    task automatic exp_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
        xfer_t e;
        e.wr = wr;
        e.a  = a;
        e.d  = d;
        mem_q.push_back(e);
    endtask

    task automatic exp_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_xfer(1'b0, base + 32'(4 * i), 32'h0);
    endtask

    // Drive one request, hold it while miss is high, count stall cycles, then
    // hold it through one more edge so a store completes as a hit.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_cyc, input bit has_rd, input logic [31:0] exp_rd);
        int cyc;
        if (has_rd) rd_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        rd_req  = rd;
        wr_req  = wr;
        addr    = a;
        wr_data = wd;
        cyc     = 0;
        forever begin
            @(negedge clk);
            if (!miss) break;
            cyc++;
            if (cyc > 200) begin
                chk({name, "_timeout"}, 32'(cyc), 32'(exp_cyc));
                break;
            end
        end
        chk({name, "_miss_cyc"}, 32'(cyc), 32'(exp_cyc));
        if (exp_cyc == 0) chk({name, "_no_mem_req"}, {30'h0, mem_rd_req, mem_wr_req}, 32'h0);
        if (has_rd) chk({name, "_rd_data"}, rd_data, rd_q.pop_front());
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        addr    = 32'h0;
        wr_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miss", {31'h0, miss}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_mem_req", {30'h0, mem_rd_req, mem_wr_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wr_data, 32'h0);
        rst = 1'b0;

        // Cold read miss, zero-wait grants.
        exp_fill(32'h10);
        access("cold_rd", 1'b1, 1'b0, 32'h10, 32'h0, 5, 1'b1, 32'h100);

        // Write hit, then read back with no memory traffic.
        access("wr_hit", 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        access("rd_hit", 1'b1, 1'b0, 32'h14, 32'h0, 0, 1'b1, 32'hDEADBEEF);

        // Dirty eviction: same index, new tag.
        exp_xfer(1'b1, 32'h10, 32'h100);
        exp_xfer(1'b1, 32'h14, 32'hDEADBEEF);
        exp_xfer(1'b1, 32'h18, 32'h102);
        exp_xfer(1'b1, 32'h1C, 32'h103);
        exp_fill(32'h90);
        access("dirty_ev", 1'b1, 1'b0, 32'h90, 32'h0, 9, 1'b1, init_word(32'h90 >> 2));
        access("ev_hit", 1'b1, 1'b0, 32'h9C, 32'h0, 0, 1'b1, init_word(32'h9C >> 2));

        // Wait states: grant every third cycle.
        gnt_period = 3;
        exp_fill(32'h30);
        access("wait_rd", 1'b1, 1'b0, 32'h38, 32'h0, 13, 1'b1, init_word(32'h38 >> 2));
        gnt_period = 1;

        // Write miss allocates then completes as a write hit.
        exp_fill(32'h70);
        access("wr_miss", 1'b0, 1'b1, 32'h70, 32'h12345678, 5, 1'b0, 32'h0);
        access("wr_miss_rd", 1'b1, 1'b0, 32'h70, 32'h0, 0, 1'b1, 32'h12345678);
        access("wr_miss_nb", 1'b1, 1'b0, 32'h74, 32'h0, 0, 1'b1, init_word(32'h74 >> 2));

        // Clean eviction: no write-back.
        exp_fill(32'hB0);
        access("clean_ev", 1'b1, 1'b0, 32'hB0, 32'h0, 5, 1'b1, init_word(32'hB0 >> 2));

        // Reset after two fill grants.
        exp_xfer(1'b0, 32'h50, 32'h0);
        exp_xfer(1'b0, 32'h54, 32'h0);
        @(posedge clk);
        #1;
        rd_req = 1'b1;
        addr   = 32'h50;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstfill_rd_req", {31'h0, mem_rd_req}, 32'h0);
        chk("rstfill_mem_addr", mem_addr, 32'h0);
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fill(32'h50);
        access("refill", 1'b1, 1'b0, 32'h50, 32'h0, 5, 1'b1, init_word(32'h50 >> 2));
        exp_fill(32'h90);
        access("post_rst", 1'b1, 1'b0, 32'h90, 32'h0, 5, 1'b1, init_word(32'h90 >> 2));

        // Simultaneous load and store on a hit acts as a store.
        access("rdwr_hit", 1'b1, 1'b1, 32'h54, 32'hCAFEF00D, 0, 1'b0, 32'h0);
        access("rdwr_rd", 1'b1, 1'b0, 32'h54, 32'h0, 0, 1'b1, 32'hCAFEF00D);
        exp_xfer(1'b1, 32'h50, init_word(32'h50 >> 2));
        exp_xfer(1'b1, 32'h54, 32'hCAFEF00D);
        exp_xfer(1'b1, 32'h58, init_word(32'h58 >> 2));
        exp_xfer(1'b1, 32'h5C, init_word(32'h5C >> 2));
        exp_fill(32'hD0);
        access("rdwr_ev", 1'b1, 1'b0, 32'hD0, 32'h0, 9, 1'b1, init_word(32'hD0 >> 2));

        repeat (2) @(posedge clk);
        #1;
        chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and the data memory bus. It produces the `DCacheMiss` stall request that the pipeline hazard logic consumes: while `miss` is high, the pipeline holds the MEM-stage request stable. The controller evicts dirty lines and refills lines word-by-word over a req/gnt memory handshake.

## Interface
- `LINE_ADDR_LEN`, default 2: words per line = 2^LINE_ADDR_LEN (default 4).
- `SET_ADDR_LEN`, default 3: lines = 2^SET_ADDR_LEN (default 8).
- Derived tag width: TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_req` in 1: MEM-stage load.
- `wr_req` in 1: MEM-stage store.
- `addr` in 32: byte address; bits [1:0] ignored.
- `wr_data` in 32: store word.
- `rd_data` out 32: load word, valid on hit.
- `miss` out 1: stall request, wired to the hazard unit `DCacheMiss`.
- `mem_rd_req` out 1: word read request to memory.
- `mem_wr_req` out 1: word write request to memory.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wr_data` out 32: write-back word.
- `mem_rd_data` in 32: refill word, valid when `mem_gnt` is high during a read.
- `mem_gnt` in 1: one-cycle accept or completion of the current word.

## Operation
- **Address split:** tag = addr[31 : 2+LINE+SET], index = next SET bits, word = addr[2+LINE-1 : 2].
- **Per-line storage:** valid, dirty, tag, and 2^LINE words, all in registers.
- **Hit condition:** valid[index] and tag matches.
- **Request arbitration:** `wr_req` has priority if both requests are high (illegal, but defined).
- **States:**
  - IDLE: lookup.
  - WB: write back the victim line.
  - FILL: refill the line.
- **IDLE behaviour:**
  - No request: nothing happens.
  - Read hit: `rd_data` = line word, combinational.
  - Write hit: the word is written at the clock edge and dirty is set.
  - Miss with victim valid and dirty: go to WB, word counter = 0.
  - Any other miss: go to FILL, word counter = 0.
- **WB state:**
  - `mem_wr_req` = 1.
  - `mem_addr` = {victim tag, index, cnt, 2'b00}.
  - `mem_wr_data` = victim word[cnt].
  - Each `mem_gnt` increments cnt; the grant on the last word goes to FILL with cnt = 0.
- **FILL state:**
  - `mem_rd_req` = 1.
  - `mem_addr` = {req tag, index, cnt, 2'b00}.
  - Each `mem_gnt` stores `mem_rd_data` into word[cnt] and increments cnt.
  - The grant on the last word sets valid, writes the tag, clears dirty, and returns to IDLE.
- **Retry after refill:** the held request then hits in IDLE. A store completes as a write hit (write-allocate).
- **`miss` output:** `miss` = (state != IDLE) | ((rd_req | wr_req) & ~hit). It is combinational so the stall applies in the miss cycle itself.
- **Memory request exclusivity:** `mem_rd_req` and `mem_wr_req` are never both high. Both are 0 in IDLE.
- **Outputs outside their state:** `mem_addr` and `mem_wr_data` are 0 when no memory request is active.
- **Request changes mid-operation:** requests are sampled only in IDLE. A request change during WB/FILL is ignored; the pipeline guarantees stability while stalled.

## Timing
- **Reset values:**
  - state = IDLE, cnt = 0.
  - All valid and dirty bits = 0. Tag and data contents are don't-care.
  - `miss` = 0 when no request is present.
  - `mem_rd_req` = `mem_wr_req` = 0, `mem_addr` = 0, `mem_wr_data` = 0, `rd_data` = 0 (line invalid).
- **Reset mid-WB/FILL:** aborts immediately and asynchronously. Memory requests drop in the same cycle, and dirty data is lost.
- **Hit latency:** zero cycles; `miss` stays 0.
- **Clean miss, zero-wait `mem_gnt`:**
  - `miss` is high for 1 + 2^LINE cycles.
  - Data is valid in the following cycle, with `miss` = 0.
- **Dirty miss:** adds 2^LINE cycles of WB.
- **Wait states:** each memory wait cycle extends the stall by one cycle. `mem_addr` and the request stay stable until `mem_gnt`.
- **Same-cycle grant:** `mem_gnt` in the first cycle of a request is legal.
- **cnt wrap:** cnt is LINE bits wide and wraps to 0 on the last grant.

## Test plan
- **Cold read miss:** reset, `rd_req`, addr 0x0000_0010, `mem_gnt` tied high, memory word n = 0x100+n.
  - `miss` is high 5 cycles; `mem_addr` sequence 0x10, 0x14, 0x18, 0x1C.
  - Cycle 6: `miss` = 0, `rd_data` = 0x100.
- **Write hit then read:** after the line above is filled, store 0xDEADBEEF to 0x14.
  - `miss` = 0 throughout.
  - A load from 0x14 returns 0xDEADBEEF, and no memory request is issued.
- **Dirty eviction:** with the line dirty from the previous test, load 0x0000_0090 (same index, new tag).
  - WB writes 4 words to 0x10..0x1C, including 0xDEADBEEF at 0x14.
  - FILL then reads 0x90..0x9C.
  - `miss` is high 9 cycles.
- **Wait states:** `mem_gnt` high every third cycle during FILL.
  - `miss` is high 1 + 12 cycles.
  - `mem_addr` is stable between grants, and the data is correct.
- **Reset mid-FILL:** assert `rst` after 2 grants.
  - `mem_rd_req` = 0 immediately.
  - A subsequent load to the same address misses again (valid cleared).
- **Simultaneous `rd_req` and `wr_req`:** both high on a hit.
  - Treated as a write: the word updates and dirty is set.
